// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined RV32I/RV64I immediate generator with elastic slices (optional IMM_CSR_EN)
module imm_gen_pipe #(
    parameter int XLEN   = 32,
    parameter int STAGES = 1,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_has_imm,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_SH   = 3'd6;
    localparam logic [2:0] FMT_Z    = 3'd7;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
`ifdef IMM_CSR_EN
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
`endif

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [31:0]     dec_imm32;
    logic            dec_sext;
    logic [2:0]      dec_fmt;
    logic [XLEN-1:0] dec_imm;

    assign opcode = in_inst[6:0];
    assign funct3 = in_inst[14:12];

    // Decode into a 32-bit immediate plus a sign/zero-extension choice
    always_comb begin
        dec_imm32 = 32'd0;
        dec_fmt   = FMT_NONE;
        dec_sext  = 1'b1;
        case (opcode)
            OP_LOAD, OP_JALR: begin
                dec_fmt   = FMT_I;
                dec_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
            end
            OP_IMM: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    // funct7/funct6 sits above shamt and must not reach imm
                    dec_fmt   = FMT_SH;
                    dec_sext  = 1'b0;
                    dec_imm32 = (XLEN == 64) ? {26'd0, in_inst[25:20]} : {27'd0, in_inst[24:20]};
                end else begin
                    dec_fmt   = FMT_I;
                    dec_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
                end
            end
            OP_IMM32: begin
                // Word ops exist only on RV64; on RV32 the opcode is reserved
                if (XLEN == 64) begin
                    if (funct3 == 3'b001 || funct3 == 3'b101) begin
                        dec_fmt   = FMT_SH;
                        dec_sext  = 1'b0;
                        dec_imm32 = {27'd0, in_inst[24:20]};
                    end else begin
                        dec_fmt   = FMT_I;
                        dec_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
                    end
                end
            end
            OP_STORE: begin
                dec_fmt   = FMT_S;
                dec_imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            end
            OP_BRANCH: begin
                dec_fmt   = FMT_B;
                dec_imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                dec_fmt   = FMT_U;
                dec_imm32 = {in_inst[31:12], 12'd0};
            end
            OP_JAL: begin
                dec_fmt   = FMT_J;
                dec_imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
            end
`ifdef IMM_CSR_EN
            OP_SYSTEM: begin
                if (funct3 == 3'b101 || funct3 == 3'b110 || funct3 == 3'b111) begin
                    dec_fmt   = FMT_Z;
                    dec_sext  = 1'b0;
                    dec_imm32 = {27'd0, in_inst[19:15]};
                end else if (funct3 == 3'b001 || funct3 == 3'b010 || funct3 == 3'b011) begin
                    // CSR address is an unsigned 12-bit index
                    dec_fmt   = FMT_I;
                    dec_sext  = 1'b0;
                    dec_imm32 = {20'd0, in_inst[31:20]};
                end
            end
`endif
            default: begin
                dec_fmt   = FMT_NONE;
                dec_imm32 = 32'd0;
            end
        endcase
    end

    assign dec_imm = dec_sext ? XLEN'($signed(dec_imm32)) : XLEN'(dec_imm32);

    logic [STAGES-1:0]             v_q;
    logic [STAGES-1:0][XLEN-1:0]   imm_q;
    logic [STAGES-1:0][2:0]        fmt_q;
    logic [STAGES-1:0][TAG_W-1:0]  tag_q;

    logic [STAGES-1:0]             v_in;
    logic [STAGES-1:0][XLEN-1:0]   imm_in;
    logic [STAGES-1:0][2:0]        fmt_in;
    logic [STAGES-1:0][TAG_W-1:0]  tag_in;
    logic [STAGES-1:0]             rdy;
    logic                          rdy_acc;

    // Each slice is fed by the decoder (slice 0) or by the slice before it
    always_comb begin
        v_in[0]   = in_valid;
        imm_in[0] = dec_imm;
        fmt_in[0] = dec_fmt;
        tag_in[0] = in_tag;
        for (int k = 1; k < STAGES; k++) begin
            v_in[k]   = v_q[k-1];
            imm_in[k] = imm_q[k-1];
            fmt_in[k] = fmt_q[k-1];
            tag_in[k] = tag_q[k-1];
        end
    end

    // Slice k can take an entry if any slice from k onward has a hole, or the consumer drains
    always_comb begin
        rdy     = '0;
        rdy_acc = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            rdy_acc = out_ready;
            for (int j = k; j < STAGES; j++) begin
                rdy_acc = rdy_acc | ~v_q[j];
            end
            rdy[k] = rdy_acc;
        end
    end

    // Slice registers: flush kills valid bits and blocks any load in the same cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            v_q   <= '0;
            imm_q <= '0;
            fmt_q <= '0;
            tag_q <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (flush) begin
                    v_q[k] <= 1'b0;
                end else if (rdy[k]) begin
                    v_q[k] <= v_in[k];
                end
                if (rdy[k] && v_in[k] && !flush) begin
                    imm_q[k] <= imm_in[k];
                    fmt_q[k] <= fmt_in[k];
                    tag_q[k] <= tag_in[k];
                end
            end
        end
    end

    assign in_ready    = rdy[0];
    assign out_valid   = v_q[STAGES-1];
    assign out_imm     = imm_q[STAGES-1];
    assign out_fmt     = fmt_q[STAGES-1];
    assign out_has_imm = (fmt_q[STAGES-1] != FMT_NONE);
    assign out_tag     = tag_q[STAGES-1];

endmodule
